// File: rtl/matrix_lsu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matrix_lsu_seq                                               |
// | Description : Multi-beat matrix load/store sequencer for the MEM stage.    |
// |               Moves one LANES x XLEN matrix register over the XLEN port.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module matrix_lsu_seq #(
    parameter int LANES  = 4,
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    is_load_i,
    input  logic                    is_store_i,
    input  logic [ADDR_W-1:0]       base_addr_i,
    input  logic [LANES*XLEN-1:0]   st_data_i,
    input  logic [4:0]              rd_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [XLEN-1:0]         mem_wdata_o,
    input  logic                    mem_ready_i,
    input  logic [XLEN-1:0]         mem_rdata_i,
    output logic                    stall_o,
    output logic                    done_o,
    output logic                    wb_en_o,
    output logic [4:0]              rd_o,
    output logic [LANES*XLEN-1:0]   matrix_o,
    output logic                    err_o
);

    localparam int MAT_W  = LANES * XLEN;
    localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [ADDR_W-1:0]   base_q;
    logic [MAT_W-1:0]    st_data_q;
    logic [4:0]          rd_q;
    logic                is_load_q;
    logic [MAT_W-1:0]    shadow_q;
    logic [MAT_W-1:0]    matrix_q;
    logic                err_q;

    logic                w_idle;
    logic                w_xfer;
    logic                w_one_op;
    logic                w_both_op;
    logic                w_aligned;
    logic                w_accept;
    logic                w_reject;
    logic [MAT_W-1:0]    matrix_d;

    assign w_idle    = (state_q == S_IDLE);
    assign w_xfer    = (state_q == S_XFER);
    assign w_one_op  = is_load_i ^ is_store_i;
    assign w_both_op = is_load_i & is_store_i;
    assign w_aligned = (base_addr_i[1:0] == 2'b00);
    assign w_accept  = w_idle & start_i & w_one_op & w_aligned;
    // A start with neither op set is a no-op, not an error.
    assign w_reject  = w_idle & start_i & (w_both_op | (w_one_op & ~w_aligned));

    // Final lane comes straight from the bus so the whole matrix lands in one edge.
    assign matrix_d  = {mem_rdata_i, shadow_q[MAT_W-XLEN-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            base_q    <= '0;
            st_data_q <= '0;
            rd_q      <= '0;
            is_load_q <= 1'b0;
            shadow_q  <= '0;
            matrix_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= w_reject;
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        state_q   <= S_XFER;
                        beat_q    <= '0;
                        base_q    <= base_addr_i;
                        st_data_q <= st_data_i;
                        rd_q      <= rd_i;
                        is_load_q <= is_load_i;
                    end
                end
                S_XFER: begin
                    if (mem_ready_i) begin
                        if (is_load_q) begin
                            shadow_q[beat_q*XLEN +: XLEN] <= mem_rdata_i;
                        end
                        if (beat_q == LAST_BEAT) begin
                            state_q <= S_DONE;
                            if (is_load_q) begin
                                matrix_q <= matrix_d;
                            end
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = w_xfer;
    assign mem_we_o    = w_xfer & ~is_load_q;
    assign mem_addr_o  = w_xfer ? (base_q + (ADDR_W'(beat_q) << 2)) : '0;
    assign mem_wdata_o = w_xfer ? st_data_q[beat_q*XLEN +: XLEN] : '0;
    assign stall_o     = w_xfer | w_accept;
    assign done_o      = (state_q == S_DONE);
    assign wb_en_o     = done_o & is_load_q;
    assign rd_o        = rd_q;
    assign matrix_o    = matrix_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_lsu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_matrix_lsu_seq                                            |
// | Description : Directed self-checking bench with a beat scoreboard.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_matrix_lsu_seq;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          is_load_i;
    logic          is_store_i;
    logic [31:0]   base_addr_i;
    logic [127:0]  st_data_i;
    logic [4:0]    rd_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_ready_i;
    logic [31:0]   mem_rdata_i;
    logic          stall_o;
    logic          done_o;
    logic          wb_en_o;
    logic [4:0]    rd_o;
    logic [127:0]  matrix_o;
    logic          err_o;

    matrix_lsu_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .is_load_i   (is_load_i),
        .is_store_i  (is_store_i),
        .base_addr_i (base_addr_i),
        .st_data_i   (st_data_i),
        .rd_i        (rd_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .wb_en_o     (wb_en_o),
        .rd_o        (rd_o),
        .matrix_o    (matrix_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Memory responder: optional wait cycles on one beat, data derived from address.
    int          tb_beat = 0;
    int          tb_wcnt = 0;
    int          wait_beat = -1;
    int          wait_cycles = 0;
    logic [31:0] rbase = 32'h0;

    always @(posedge clk) begin
        if (rst || !mem_req_o) begin
            tb_beat <= 0;
            tb_wcnt <= 0;
        end else if (mem_ready_i) begin
            tb_beat <= tb_beat + 1;
            tb_wcnt <= 0;
        end else begin
            tb_wcnt <= tb_wcnt + 1;
        end
    end

    assign mem_ready_i = mem_req_o && !((tb_beat == wait_beat) && (tb_wcnt < wait_cycles));
    assign mem_rdata_i = rbase + {30'b0, mem_addr_o[3:2]};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every presented beat is compared to the scoreboard head; it pops only on handshake,
    // so wait cycles also verify address/data/we stability.
    always @(negedge clk) begin
        if (!rst && mem_req_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", mem_req_o, 1'b0);
            end else begin
                chk("beat_addr",  mem_addr_o,  exp_q[0].addr);
                chk("beat_we",    mem_we_o,    exp_q[0].we);
                chk("beat_wdata", mem_wdata_o, exp_q[0].wdata);
                if (mem_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_beats(input logic ld, input logic [31:0] base, input logic [127:0] sd);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.addr  = base + 32'(4 * k);
            b.we    = !ld;
            b.wdata = sd[k*32 +: 32];
            exp_q.push_back(b);
        end
    endtask

    function automatic logic [127:0] load_mat(input logic [31:0] base);
        logic [127:0] m;
        logic [31:0]  a;
        for (int k = 0; k < 4; k++) begin
            a = base + 32'(4 * k);
            m[k*32 +: 32] = rbase + {30'b0, a[3:2]};
        end
        return m;
    endfunction

    // Called on a negedge in IDLE; returns on the negedge of the first beat cycle.
    task automatic issue(input logic ld, input logic [31:0] base, input logic [127:0] sd,
                         input logic [4:0] rd);
        start_i = 1'b1; is_load_i = ld; is_store_i = !ld;
        base_addr_i = base; st_data_i = sd; rd_i = rd;
        push_beats(ld, base, sd);
        #1 chk("stall_accept", stall_o, 1'b1);
        @(negedge clk);
        start_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, input logic ld, input logic [4:0] rd,
                             input logic [127:0] mat);
        int n = 1;
        while (!done_o && n < 60) begin
            chk("stall_xfer", stall_o, 1'b1);
            @(negedge clk);
            n++;
        end
        chk("latency",    n,         exp_lat);
        chk("done",       done_o,    1'b1);
        chk("wb_en",      wb_en_o,   ld);
        chk("rd_out",     rd_o,      rd);
        chk("matrix",     matrix_o,  mat);
        chk("stall_done", stall_o,   1'b0);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    task automatic check_reject(input logic ld, input logic st, input logic [31:0] base,
                                input logic exp_err);
        start_i = 1'b1; is_load_i = ld; is_store_i = st; base_addr_i = base;
        #1 chk("rej_stall", stall_o, 1'b0);
        @(negedge clk);
        start_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        chk("rej_err",   err_o,     exp_err);
        chk("rej_req",   mem_req_o, 1'b0);
        @(negedge clk);
        chk("rej_err_clear", err_o, 1'b0);
        chk("rej_req2",  mem_req_o, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},    mem_req_o,   1'b0);
        chk({tag, "_we"},     mem_we_o,    1'b0);
        chk({tag, "_addr"},   mem_addr_o,  32'h0);
        chk({tag, "_wdata"},  mem_wdata_o, 32'h0);
        chk({tag, "_stall"},  stall_o,     1'b0);
        chk({tag, "_done"},   done_o,      1'b0);
        chk({tag, "_wb"},     wb_en_o,     1'b0);
        chk({tag, "_rd"},     rd_o,        5'h0);
        chk({tag, "_matrix"}, matrix_o,    128'h0);
        chk({tag, "_err"},    err_o,       1'b0);
    endtask

    initial begin
        logic [127:0] sd;
        logic [127:0] last_mat;
        rst = 1'b1; start_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        base_addr_i = '0; st_data_i = '0; rd_i = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait load
        rbase = 32'hA0;
        issue(1'b1, 32'h100, 128'h0, 5'd5);
        wait_done(5, 1'b1, 5'd5, 128'h000000A3_000000A2_000000A1_000000A0);
        last_mat = 128'h000000A3_000000A2_000000A1_000000A0;
        @(negedge clk);
        chk("idle_after_load_stall", stall_o, 1'b0);
        chk("matrix_held", matrix_o, last_mat);

        // Store with two wait cycles on beat 1
        wait_beat = 1; wait_cycles = 2;
        sd = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        issue(1'b0, 32'h200, sd, 5'd3);
        wait_done(7, 1'b0, 5'd3, last_mat);
        wait_beat = -1; wait_cycles = 0;
        @(negedge clk);

        // Rejected and ignored starts
        check_reject(1'b1, 1'b0, 32'h102, 1'b1);
        check_reject(1'b1, 1'b1, 32'h100, 1'b1);
        check_reject(1'b0, 1'b0, 32'h100, 1'b0);

        // Address wrap
        rbase = 32'h4000;
        issue(1'b1, 32'hFFFF_FFF8, 128'h0, 5'd6);
        wait_done(5, 1'b1, 5'd6, 128'h00004001_00004000_00004003_00004002);
        @(negedge clk);

        // Reset during beat 2
        rbase = 32'h5000;
        issue(1'b1, 32'h300, 128'h0, 5'd7);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_addr", mem_addr_o, 32'h308);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_reset_req", mem_req_o, 1'b0);
        rbase = 32'h6000;
        issue(1'b1, 32'h400, 128'h0, 5'd9);
        wait_done(5, 1'b1, 5'd9, load_mat(32'h400));
        @(negedge clk);

        // Back-to-back loads: start held across the done cycle
        rbase = 32'h7000;
        issue(1'b1, 32'h500, 128'h0, 5'd10);
        wait_done(5, 1'b1, 5'd10, load_mat(32'h500));
        rbase = 32'h8000;
        start_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0;
        base_addr_i = 32'h600; st_data_i = 128'h0; rd_i = 5'd11;
        push_beats(1'b1, 32'h600, 128'h0);
        #1 chk("b2b_stall_in_done", stall_o, 1'b0);
        @(negedge clk);
        #1 chk("b2b_stall_accept", stall_o, 1'b1);
        chk("b2b_req_accept", mem_req_o, 1'b0);
        @(negedge clk);
        start_i = 1'b0; is_load_i = 1'b0;
        wait_done(5, 1'b1, 5'd11, load_mat(32'h600));
        @(negedge clk);
        chk("final_idle_req", mem_req_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
